// File: rtl/reset_seq_bridge.sv
// rtl/reset_seq_bridge.sv - synchronised, staggered multi-channel reset release
module reset_seq_bridge #(
  parameter int    SYNC_STAGES = 2,
  parameter int    N_CH        = 4,
  parameter int    STEP_CYCLES = 16,
  parameter string OUT_RES_POL = "ACTIVE_HIGH",
  parameter string CLK_EDGE    = "POS_EDGE"
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            sw_rst_i,
  output logic [N_CH-1:0] rst_o,
  output logic            done_o
);

  // Reject illegal configurations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync
    $error("reset_seq_bridge: SYNC_STAGES must be 2..8");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("reset_seq_bridge: N_CH must be 1..16");
  end
  if (STEP_CYCLES < 1 || STEP_CYCLES > 65535) begin : g_bad_step
    $error("reset_seq_bridge: STEP_CYCLES must be 1..65535");
  end
  if (OUT_RES_POL != "ACTIVE_HIGH" && OUT_RES_POL != "ACTIVE_LOW") begin : g_bad_pol
    $error("reset_seq_bridge: OUT_RES_POL must be ACTIVE_HIGH or ACTIVE_LOW");
  end
  if (CLK_EDGE != "POS_EDGE" && CLK_EDGE != "NEG_EDGE") begin : g_bad_edge
    $error("reset_seq_bridge: CLK_EDGE must be POS_EDGE or NEG_EDGE");
  end

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam int IW = $clog2(N_CH + 1);
  localparam logic            ASSERT_LVL = (OUT_RES_POL == "ACTIVE_HIGH") ? 1'b1 : 1'b0;
  localparam logic [N_CH-1:0] RST_ON     = {N_CH{ASSERT_LVL}};
  localparam logic [CW-1:0]   STEP_V     = CW'(STEP_CYCLES);
  localparam logic [IW-1:0]   LAST_CH    = IW'(N_CH - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_SW_HOLD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Every flop runs off the selected edge; a negedge build sees an inverted clock.
  logic clk_act;
  if (CLK_EDGE == "NEG_EDGE") begin : g_neg
    assign clk_act = ~clk_i;
  end else begin : g_pos
    assign clk_act = clk_i;
  end

  state_t                 state_q, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_nxt, cnt_inc;
  logic [IW-1:0]          idx_q, idx_nxt;
  logic [N_CH-1:0]        rst_nxt;
  logic                   done_nxt;
  logic                   sync_out, step_hit, last_ch, sw_exit, counting, sw_take;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Deassertion synchroniser: ones ripple in after rst_i rises, cleared asynchronously.
  always_ff @(posedge clk_act or negedge rst_i) begin
    if (!rst_i) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Shared qualifiers for the sequencer; the first counting edge is the one that leaves HOLD.
  always_comb begin
    cnt_inc  = cnt_q + CW'(1);
    step_hit = (cnt_inc == STEP_V);
    last_ch  = (idx_q == LAST_CH);
    sw_exit  = (step_hit || (cnt_q == STEP_V)) && !sw_rst_i;
    counting = (state_q == S_RELEASE) || ((state_q == S_HOLD) && sync_out);
    sw_take  = sw_rst_i && ((state_q == S_RELEASE) || (state_q == S_DONE));
  end

  // State register.
  always_ff @(posedge clk_act or negedge rst_i) begin
    if (!rst_i) state_q <= S_HOLD;
    else        state_q <= state_nxt;
  end

  // Next-state logic; software requests are ignored in HOLD and win over a release.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_HOLD: begin
        if (sync_out) state_nxt = (step_hit && last_ch) ? S_DONE : S_RELEASE;
      end
      S_RELEASE: begin
        if (sw_rst_i)                 state_nxt = S_SW_HOLD;
        else if (step_hit && last_ch) state_nxt = S_DONE;
      end
      S_SW_HOLD: begin
        if (sw_exit) state_nxt = S_RELEASE;
      end
      S_DONE: begin
        if (sw_rst_i) state_nxt = S_SW_HOLD;
      end
      default: state_nxt = S_HOLD;
    endcase
  end

  // Output and counter next values; registered below so outputs come straight from flops.
  always_comb begin
    rst_nxt = rst_o;
    cnt_nxt = cnt_q;
    idx_nxt = idx_q;
    if ((state_q == S_HOLD) && !sync_out) begin
      rst_nxt = RST_ON;
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (sw_take) begin
      rst_nxt = RST_ON;
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (counting) begin
      if (step_hit) begin
        for (int k = 0; k < N_CH; k++) begin
          if (idx_q == IW'(k)) rst_nxt[k] = ~ASSERT_LVL;
        end
        cnt_nxt = '0;
        if (!last_ch) idx_nxt = idx_q + IW'(1);
      end else begin
        cnt_nxt = cnt_inc;
      end
    end else if (state_q == S_SW_HOLD) begin
      rst_nxt = RST_ON;
      idx_nxt = '0;
      if (sw_exit)               cnt_nxt = '0;
      else if (cnt_q != STEP_V)  cnt_nxt = cnt_inc;
    end
    done_nxt = (state_nxt == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_act or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      rst_o  <= RST_ON;
      done_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      idx_q  <= idx_nxt;
      rst_o  <= rst_nxt;
      done_o <= done_nxt;
    end
  end

endmodule

// File: doc/reset_seq_bridge.md
RESET_SEQ_BRIDGE -- requirements
Module: reset_seq_bridge

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning number of deassertion synchroniser flops (legal 2..8).
REQ-002 The block SHALL have parameter N_CH, default 4, meaning number of sequenced reset output channels (legal 1..16).
REQ-003 The block SHALL have parameter STEP_CYCLES, default 16, meaning active clock edges between successive channel releases (legal 1..65535).
REQ-004 The block SHALL have parameter OUT_RES_POL, default "ACTIVE_HIGH", meaning asserted level of rst_o and its complement when released ("ACTIVE_HIGH"/"ACTIVE_LOW").
REQ-005 The block SHALL have parameter CLK_EDGE, default "POS_EDGE", meaning active clock edge for all flops ("POS_EDGE"/"NEG_EDGE").
REQ-006 The block SHALL have port clk_i, input, 1 bit, meaning the single clock.
REQ-007 The block SHALL have port rst_i, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-008 The block SHALL have port sw_rst_i, input, 1 bit, meaning software reset request, active-high, synchronous to clk_i.
REQ-009 The block SHALL have port rst_o, output, N_CH bits, meaning per-channel reset outputs, bit k is channel k.
REQ-010 The block SHALL have port done_o, output, 1 bit, meaning high when every channel is released.
REQ-011 Illegal parameter values SHALL stop elaboration with an error.

Function
REQ-012 All flops SHALL use the CLK_EDGE edge of clk_i; "active edge" below means that edge.
REQ-013 rst_o and done_o SHALL be driven directly from flops, with no combinational logic after the flops.
REQ-014 rst_i low SHALL immediately assert every rst_o bit, drive done_o low, clear the synchroniser and counters, and force state HOLD, independent of clk_i.
REQ-015 Deassertion of rst_i SHALL be synchronised:
- SYNC_STAGES-flop chain, all asynchronously cleared by rst_i.
- First flop loads 1; each following flop loads its predecessor.
REQ-016 The FSM SHALL have exactly the states HOLD, RELEASE, SW_HOLD and DONE.
REQ-017 The FSM SHALL leave HOLD for RELEASE when the synchroniser output is high, and never before.
REQ-018 Edge 1 is the first active edge after rst_i rises. Channel k SHALL deassert on edge SYNC_STAGES + (k+1)*STEP_CYCLES.
REQ-019 Release order SHALL be strictly channel 0 first and channel N_CH-1 last; a released channel SHALL stay released until the next assertion event.
REQ-020 The FSM SHALL enter DONE, and done_o SHALL go high, on the same edge that releases channel N_CH-1.
REQ-021 sw_rst_i sampled high in RELEASE or DONE SHALL, on that edge:
- assert all rst_o bits;
- drive done_o low;
- clear the step counter;
- enter SW_HOLD.
REQ-022 sw_rst_i in HOLD SHALL be ignored.
REQ-023 SW_HOLD SHALL last at least STEP_CYCLES edges and while sw_rst_i is high.
REQ-024 On the first edge where both SW_HOLD conditions are met, the FSM SHALL enter RELEASE with the counter cleared.
REQ-025 After leaving SW_HOLD, channel k SHALL deassert (k+1)*STEP_CYCLES edges after the SW_HOLD-exit edge.
REQ-026 The step counter SHALL be ceil(log2(STEP_CYCLES+1)) bits wide and the channel index ceil(log2(N_CH+1)) bits wide; neither SHALL wrap in any state.
REQ-027 With STEP_CYCLES=1, channels SHALL release on consecutive edges.
REQ-028 With N_CH=1, done_o SHALL rise together with rst_o[0] release.
REQ-029 sw_rst_i high on the same edge as a channel release SHALL take priority: that channel stays asserted.
REQ-030 rst_i asserted in any state SHALL override sw_rst_i and all sequencing.

Reset
REQ-031 While rst_i is low:
- rst_o SHALL be all asserted (all ones for ACTIVE_HIGH, all zeros for ACTIVE_LOW);
- done_o SHALL be 0;
- the state SHALL be HOLD;
- the synchroniser and counters SHALL be 0.
REQ-032 A glitch on rst_i shorter than one clock period SHALL still produce the full REQ-018 release sequence.

Verification
REQ-033 Defaults, rst_i released before edge 1 -> rst_o[0..3] deassert on edges 18, 34, 50, 66 respectively; done_o rises on edge 66.
REQ-034 Defaults, rst_i pulsed low between edges 40 and 41 -> all rst_o assert immediately and done_o stays 0; the sequence restarts with channel 0 releasing 18 edges after rst_i rises.
REQ-035 Defaults, in DONE, sw_rst_i high for 3 edges -> all rst_o assert on edge 1 of the request and SW_HOLD lasts 16 edges; channel 0 releases 16 edges after exit and done_o rises 64 edges after exit.
REQ-036 Defaults, sw_rst_i sampled high on the release edge of channel 2 -> channels 2 and 3 stay asserted, channels 0 and 1 re-assert, and done_o is never high.
REQ-037 OUT_RES_POL="ACTIVE_LOW", CLK_EDGE="NEG_EDGE", N_CH=1, STEP_CYCLES=1, SYNC_STAGES=3 -> rst_o=0 in reset; rst_o goes to 1 and done_o to 1 on negedge 4.
REQ-038 SYNC_STAGES=1 or N_CH=0 -> elaboration error.
